matmul_gen_top: RTL and testbench

Generalised matrix-multiply subsystem. It computes Z = X·Y, or Z = Z + X·Y in accumulate mode, for non-square operands: X is M×K, Y is K×N and Z is M×N. All operands are row-major in three internal single-port-read/single-port-write BRAMs that the host loads and reads directly. It replaces the fixed square matmul top and has its own sequencing FSM, host-write protection, and an error flag.

---
 rtl/matmul_gen_top.sv | 179 +++++++++++++++++
 tb/tb_matmul_gen_top.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_gen_top.sv
// Generalised matrix multiply: Z = X*Y or Z += X*Y over row-major X (MxK), Y (KxN), Z (MxN)
// held in three internal BRAMs that the host loads and reads while the sequencer is idle.
module matmul_gen_top #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned M_DIM      = 8,
    parameter int unsigned K_DIM      = 8,
    parameter int unsigned N_DIM      = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  accum,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic [DATA_WIDTH-1:0] x_din,
    input  logic [ADDR_WIDTH-1:0] x_wr_addr,
    input  logic                  x_wr_en,
    input  logic [DATA_WIDTH-1:0] y_din,
    input  logic [ADDR_WIDTH-1:0] y_wr_addr,
    input  logic                  y_wr_en,
    input  logic [DATA_WIDTH-1:0] z_din,
    input  logic [ADDR_WIDTH-1:0] z_wr_addr,
    input  logic                  z_wr_en,
    input  logic [ADDR_WIDTH-1:0] z_addr,
    output logic [DATA_WIDTH-1:0] z_dout
);

    localparam int unsigned IW    = (M_DIM > 1) ? $clog2(M_DIM) : 1;
    localparam int unsigned JW    = (N_DIM > 1) ? $clog2(N_DIM) : 1;
    localparam int unsigned KW    = (K_DIM > 1) ? $clog2(K_DIM) : 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [IW-1:0] I_LAST = IW'(M_DIM - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N_DIM - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K_DIM - 1);

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StWrite, StDone} state_e;

    state_e                  state_q;
    logic [IW-1:0]           i_q;
    logic [JW-1:0]           j_q;
    logic [KW-1:0]           k_q;
    logic                    accum_q;
    logic [DATA_WIDTH-1:0]   acc_q;

    logic [DATA_WIDTH-1:0]   x_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   y_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   z_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   x_q;
    logic [DATA_WIDTH-1:0]   y_q;
    logic [DATA_WIDTH-1:0]   z_q;

    logic [ADDR_WIDTH-1:0]   x_rd_addr;
    logic [ADDR_WIDTH-1:0]   y_rd_addr;
    logic [ADDR_WIDTH-1:0]   z_elem_addr;
    logic [ADDR_WIDTH-1:0]   z_rd_addr;
    logic                    add_en;
    logic                    seq_wr;
    logic                    z_rd_en;
    logic                    host_wr;
    logic [DATA_WIDTH-1:0]   prod;
    logic [DATA_WIDTH-1:0]   z_wr_data;

    always_comb begin
        x_rd_addr   = ADDR_WIDTH'(i_q * K_DIM + k_q);
        y_rd_addr   = ADDR_WIDTH'(k_q * N_DIM + j_q);
        z_elem_addr = ADDR_WIDTH'(i_q * N_DIM + j_q);
        // BRAM data for RUN cycle k arrives in cycle k+1; DRAIN picks up the last one.
        add_en      = ((state_q == StRun) && (k_q != '0)) || (state_q == StDrain);
        seq_wr      = (state_q == StWrite);
        // z_q then holds Z[i][j] unchanged until WRITE consumes it.
        z_rd_en     = !busy || ((state_q == StRun) && (k_q == '0) && accum_q);
        z_rd_addr   = busy ? z_elem_addr : z_addr;
        host_wr     = x_wr_en | y_wr_en | z_wr_en;
        prod        = DATA_WIDTH'($signed(x_q) * $signed(y_q));
        z_wr_data   = accum_q ? (acc_q + z_q) : acc_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            accum_q <= 1'b0;
            acc_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy && host_wr) begin
                err <= 1'b1;
            end
            if (add_en) begin
                acc_q <= acc_q + prod;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        accum_q <= accum;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                    end
                end
                StRun: begin
                    if (k_q == K_LAST) begin
                        k_q     <= '0;
                        state_q <= StDrain;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                StDrain: begin
                    state_q <= StWrite;
                end
                StWrite: begin
                    acc_q <= '0;
                    if (j_q == J_LAST) begin
                        j_q <= '0;
                        if (i_q == I_LAST) begin
                            i_q     <= '0;
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            i_q     <= i_q + 1'b1;
                            state_q <= StRun;
                        end
                    end else begin
                        j_q     <= j_q + 1'b1;
                        state_q <= StRun;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Memories are not reset, so a partial Z result survives a mid-run reset.
    always_ff @(posedge clock) begin
        if (x_wr_en && !busy) begin
            x_mem[x_wr_addr] <= x_din;
        end
        if (y_wr_en && !busy) begin
            y_mem[y_wr_addr] <= y_din;
        end
        if (seq_wr) begin
            z_mem[z_elem_addr] <= z_wr_data;
        end else if (z_wr_en && !busy) begin
            z_mem[z_wr_addr] <= z_din;
        end
        x_q <= x_mem[x_rd_addr];
        y_q <= y_mem[y_rd_addr];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            z_q <= '0;
        end else if (z_rd_en) begin
            z_q <= z_mem[z_rd_addr];
        end
    end

    assign z_dout = z_q;

endmodule

// File: tb/tb_matmul_gen_top.sv
// Directed bench for matmul_gen_top: default 8x8x8 instance plus 2x3x4 and 1x1x1 instances.
module tb_matmul_gen_top;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    // 8x8x8 instance
    logic        start8, accum8, busy8, done8, err8;
    logic [31:0] x_din8, y_din8, z_din8, z_dout8;
    logic [5:0]  x_wa8, y_wa8, z_wa8, z_addr8;
    logic        x_we8, y_we8, z_we8;

    // 2x3x4 instance
    logic        start_ns, accum_ns, busy_ns, done_ns, err_ns;
    logic [31:0] x_din_ns, y_din_ns, z_din_ns, z_dout_ns;
    logic [3:0]  x_wa_ns, y_wa_ns, z_wa_ns, z_addr_ns;
    logic        x_we_ns, y_we_ns, z_we_ns;

    // 1x1x1 instance
    logic        start1, accum1, busy1, done1, err1;
    logic [31:0] x_din1, y_din1, z_din1, z_dout1;
    logic [0:0]  x_wa1, y_wa1, z_wa1, z_addr1;
    logic        x_we1, y_we1, z_we1;

    matmul_gen_top dut8 (
        .clock(clock), .reset(reset), .start(start8), .accum(accum8),
        .busy(busy8), .done(done8), .err(err8),
        .x_din(x_din8), .x_wr_addr(x_wa8), .x_wr_en(x_we8),
        .y_din(y_din8), .y_wr_addr(y_wa8), .y_wr_en(y_we8),
        .z_din(z_din8), .z_wr_addr(z_wa8), .z_wr_en(z_we8),
        .z_addr(z_addr8), .z_dout(z_dout8)
    );

    matmul_gen_top #(.DATA_WIDTH(32), .M_DIM(2), .K_DIM(3), .N_DIM(4), .ADDR_WIDTH(4)) dut_ns (
        .clock(clock), .reset(reset), .start(start_ns), .accum(accum_ns),
        .busy(busy_ns), .done(done_ns), .err(err_ns),
        .x_din(x_din_ns), .x_wr_addr(x_wa_ns), .x_wr_en(x_we_ns),
        .y_din(y_din_ns), .y_wr_addr(y_wa_ns), .y_wr_en(y_we_ns),
        .z_din(z_din_ns), .z_wr_addr(z_wa_ns), .z_wr_en(z_we_ns),
        .z_addr(z_addr_ns), .z_dout(z_dout_ns)
    );

    matmul_gen_top #(.DATA_WIDTH(32), .M_DIM(1), .K_DIM(1), .N_DIM(1), .ADDR_WIDTH(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .accum(accum1),
        .busy(busy1), .done(done1), .err(err1),
        .x_din(x_din1), .x_wr_addr(x_wa1), .x_wr_en(x_we1),
        .y_din(y_din1), .y_wr_addr(y_wa1), .y_wr_en(y_we1),
        .z_din(z_din1), .z_wr_addr(z_wa1), .z_wr_en(z_we1),
        .z_addr(z_addr1), .z_dout(z_dout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // sel: 0 = X, 1 = Y, 2 = Z
    task automatic wr8(input int sel, input int addr, input logic [31:0] data);
        x_we8 = (sel == 0); y_we8 = (sel == 1); z_we8 = (sel == 2);
        x_wa8 = 6'(addr); y_wa8 = 6'(addr); z_wa8 = 6'(addr);
        x_din8 = data; y_din8 = data; z_din8 = data;
        tick();
        x_we8 = 1'b0; y_we8 = 1'b0; z_we8 = 1'b0;
    endtask

    task automatic rd8(input int addr, output logic [31:0] data);
        z_addr8 = 6'(addr);
        tick();
        data = z_dout8;
    endtask

    task automatic check_z8(input string tag, input int offset, input int scale);
        logic [31:0] d;
        for (int a = 0; a < 64; a++) begin
            rd8(a, d);
            check(tag, d, 32'(scale * a + offset));
        end
    endtask

    // Runs dut8 from the current cycle (cycle 0). A nonzero wr_cyc drops a host X write there;
    // a nonzero rst_cyc asserts reset in that cycle and abandons the run.
    task automatic run8(input logic acc, input int wr_cyc, input int rst_cyc, output int cyc);
        start8 = 1'b1;
        accum8 = acc;
        cyc = 0;
        while (cyc < 2000) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                start8 = 1'b0;
                check("busy_in_run", busy8, 1);
                check("err_clear_on_start", err8, 0);
            end
            if (wr_cyc != 0 && cyc == wr_cyc) begin
                check("err_before_write", err8, 0);
                x_we8 = 1'b1; x_wa8 = 6'd0; x_din8 = 32'd7;
            end
            if (wr_cyc != 0 && cyc == wr_cyc + 1) begin
                x_we8 = 1'b0;
                check("err_after_write", err8, 1);
            end
            if (rst_cyc != 0 && cyc == rst_cyc) begin
                check("err_before_reset", err8, 1);
                reset = 1'b0;
                #1;
                check("reset_busy", busy8, 0);
                check("reset_done", done8, 0);
                check("reset_err", err8, 0);
                check("reset_zdout", z_dout8, 0);
                tick();
                reset = 1'b1;
                break;
            end
            if (done8) begin
                check("busy_low_at_done", busy8, 0);
                break;
            end
        end
    endtask

    int          ns_exp [8] = '{8, 14, 20, 26, 17, 32, 47, 62};
    int          x_ns [6]   = '{1, 2, 3, 4, 5, 6};
    int          cyc;
    logic [31:0] d;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        {start8, accum8, x_we8, y_we8, z_we8} = '0;
        {x_din8, y_din8, z_din8, x_wa8, y_wa8, z_wa8, z_addr8} = '0;
        {start_ns, accum_ns, x_we_ns, y_we_ns, z_we_ns} = '0;
        {x_din_ns, y_din_ns, z_din_ns, x_wa_ns, y_wa_ns, z_wa_ns, z_addr_ns} = '0;
        {start1, accum1, x_we1, y_we1, z_we1} = '0;
        {x_din1, y_din1, z_din1, x_wa1, y_wa1, z_wa1, z_addr1} = '0;
        #1;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_err", err8, 0);
        check("rst_zdout", z_dout8, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Identity X, Y[k][j] = 8k+j
        for (int a = 0; a < 64; a++) begin
            wr8(0, a, (a / 8 == a % 8) ? 32'd1 : 32'd0);
            wr8(1, a, 32'(a));
        end
        run8(1'b0, 0, 0, cyc);
        check("ident_done_cycle", cyc, 641);
        check("ident_err", err8, 0);
        tick();
        check("done_one_pulse", done8, 0);
        check_z8("ident_z", 0, 1);

        // Same-address write and read in one idle cycle returns old data
        z_we8 = 1'b1; z_wa8 = 6'd5; z_din8 = 32'h1234; z_addr8 = 6'd5;
        tick();
        z_we8 = 1'b0;
        check("rdw_old_data", z_dout8, 5);
        tick();
        check("rdw_new_data", z_dout8, 32'h1234);

        // Accumulate onto Z preloaded with 100
        for (int a = 0; a < 64; a++) wr8(2, a, 32'd100);
        run8(1'b1, 0, 0, cyc);
        check("accum_done_cycle", cyc, 641);
        tick();
        check_z8("accum_z", 100, 1);

        // Dropped X write in cycle 5; result matches a clean identity run
        run8(1'b0, 5, 0, cyc);
        check("prot_done_cycle", cyc, 641);
        tick();
        check("prot_err_sticky", err8, 1);
        check_z8("prot_z", 0, 1);

        // Reset in cycle 20 (after a dropped write in cycle 10), then clean runs
        run8(1'b0, 10, 20, cyc);
        tick();
        for (int a = 0; a < 64; a++) wr8(2, a, 32'hDEADBEEF);
        run8(1'b0, 0, 0, cyc);
        check("post_reset_done_cycle", cyc, 641);
        tick();
        // Back-to-back: start in the cycle right after done
        run8(1'b1, 0, 0, cyc);
        check("b2b_done_cycle", cyc, 641);
        tick();
        check_z8("b2b_z", 0, 2);

        // 2x3x4: X = [1 2 3; 4 5 6], Y[k][j] = k+j
        for (int a = 0; a < 6; a++) begin
            x_we_ns = 1'b1; x_wa_ns = 4'(a); x_din_ns = 32'(x_ns[a]);
            tick();
        end
        x_we_ns = 1'b0;
        for (int a = 0; a < 12; a++) begin
            y_we_ns = 1'b1; y_wa_ns = 4'(a); y_din_ns = 32'(a / 4 + a % 4);
            tick();
        end
        y_we_ns = 1'b0;
        start_ns = 1'b1;
        cyc = 0;
        while (cyc < 200) begin
            tick();
            cyc++;
            start_ns = 1'b0;
            if (done_ns) break;
        end
        check("ns_done_cycle", cyc, 41);
        tick();
        for (int a = 0; a < 8; a++) begin
            z_addr_ns = 4'(a);
            tick();
            check("ns_z", z_dout_ns, 32'(ns_exp[a]));
        end

        // 1x1x1: (-1) * 0x80000000 wraps to 0x80000000
        x_we1 = 1'b1; x_din1 = 32'hFFFF_FFFF;
        y_we1 = 1'b1; y_din1 = 32'h8000_0000;
        tick();
        x_we1 = 1'b0; y_we1 = 1'b0;
        start1 = 1'b1;
        cyc = 0;
        while (cyc < 100) begin
            tick();
            cyc++;
            start1 = 1'b0;
            if (done1) break;
        end
        check("one_done_cycle", cyc, 4);
        tick();
        z_addr1 = 1'b0;
        tick();
        check("one_z", z_dout1, 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
